// File: rtl/median_pkg.sv
// Shared types and helpers for the median sequencer and its MED element.
package median_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SORT,
        FINAL,
        DONE
    } state_t;

    // Full compare/rotate passes needed before the median reaches the head.
    function automatic int npass(input int p);
        return (p - 1) / 2;
    endfunction

    // Cycles from the first accepted sample to the DSO pulse.
    function automatic int lat(input int p);
        return p + npass(p) * p + (p - 1 - npass(p));
    endfunction

endpackage

// File: rtl/median_seq_med.sv
// MED element: ring of P sample registers with a max-retaining head stage.
module med
    import median_pkg::*;
#(
    parameter int W = 8,
    parameter int P = 9
) (
    input  logic         clk,
    input  logic [W-1:0] sample,
    input  logic         dsi,
    input  logic         byp,
    output logic [W-1:0] head
);

    logic [W-1:0] r   [P];
    logic [W-1:0] nxt [P];
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] head_next;
    logic [W-1:0] tail_next;

    // Compare keeps the larger of head and next-in-line; the smaller rejoins the tail.
    always_comb begin
        if (r[0] >= r[1]) begin
            hi = r[0];
            lo = r[1];
        end else begin
            hi = r[1];
            lo = r[0];
        end
        head_next = byp ? r[1] : hi;
        tail_next = dsi ? sample : (byp ? r[0] : lo);
    end

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign nxt[gi] = head_next;
            end else if (gi == P - 1) begin : g_tail
                assign nxt[gi] = tail_next;
            end else begin : g_mid
                assign nxt[gi] = r[gi + 1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < P; k++) begin
            r[k] <= nxt[k];
        end
    end

    assign head = r[0];

endmodule

// File: rtl/median_seq.sv
// Sequencer: loads one P-sample burst into MED, runs the sort passes, presents the median.
module median_seq
    import median_pkg::*;
#(
    parameter int W = 8,
    parameter int P = 9
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] DI,
    input  logic         DSI,
    output logic [W-1:0] DO,
    output logic         DSO,
    output logic         BUSY,
    output logic         ERR
);

    localparam int NP = npass(P);
    localparam int CW = $clog2(P + 1);
    localparam logic [CW-1:0] LAST_LOAD  = CW'(P - 1);
    localparam logic [CW-1:0] LAST_CYC   = CW'(P - 1);
    localparam logic [CW-1:0] LAST_PASS  = CW'(NP - 1);
    localparam logic [CW-1:0] LAST_FINAL = CW'(P - 2 - NP);
    localparam logic [CW:0]   CMP_LIMIT  = (CW + 1)'(P - 2);

    state_t          state_reg, state_next;
    logic [CW-1:0]   load_reg, load_next;
    logic [CW-1:0]   pass_reg, pass_next;
    logic [CW-1:0]   cyc_reg, cyc_next;
    logic            med_dsi;
    logic            med_byp;
    logic [W-1:0]    med_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            load_reg  <= '0;
            pass_reg  <= '0;
            cyc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            load_reg  <= load_next;
            pass_reg  <= pass_next;
            cyc_reg   <= cyc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_next  = load_reg;
        pass_next  = pass_reg;
        cyc_next   = cyc_reg;
        med_dsi    = 1'b0;
        med_byp    = 1'b1;
        ERR        = 1'b0;
        unique case (state_reg)
            IDLE, DONE: begin
                med_dsi = DSI;
                if (DSI) begin
                    state_next = LOAD;
                    load_next  = CW'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                med_dsi = DSI;
                if (DSI) begin
                    load_next = load_reg + 1'b1;
                    if (load_reg == LAST_LOAD) begin
                        state_next = SORT;
                        pass_next  = '0;
                        cyc_next   = '0;
                    end
                end else begin
                    ERR        = !RST;
                    state_next = IDLE;
                    load_next  = '0;
                end
            end
            SORT: begin
                // Pass i compares for P-1-i cycles, then rotates the sorted tail back behind.
                med_byp = ({1'b0, cyc_reg} + {1'b0, pass_reg}) > CMP_LIMIT;
                if (cyc_reg == LAST_CYC) begin
                    cyc_next = '0;
                    if (pass_reg == LAST_PASS) begin
                        state_next = FINAL;
                    end else begin
                        pass_next = pass_reg + 1'b1;
                    end
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            FINAL: begin
                med_byp = 1'b0;
                if (cyc_reg == LAST_FINAL) begin
                    state_next = DONE;
                    cyc_next   = '0;
                    pass_next  = '0;
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    med #(.W(W), .P(P)) u_med (
        .clk    (CLK),
        .sample (DI),
        .dsi    (med_dsi),
        .byp    (med_byp),
        .head   (med_q)
    );

    assign DO   = med_q;
    assign DSO  = (state_reg == DONE);
    assign BUSY = !RST && ((state_reg != IDLE) || DSI);

endmodule

// File: tb/tb_median_seq.sv
// Randomised scoreboard bench for median_seq: sorted-array reference, decoupled monitor.
module tb_median_seq;

    localparam int W   = 8;
    localparam int P   = 9;
    localparam int NP  = (P - 1) / 2;
    localparam int LAT = P + NP * P + (P - 1 - NP);

    logic         clk = 1'b0;
    logic         rst;
    logic         dsi;
    logic [W-1:0] di;
    logic [W-1:0] dout;
    logic         dso;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    median_seq #(.W(W), .P(P)) dut (
        .CLK  (clk),
        .RST  (rst),
        .DI   (di),
        .DSI  (dsi),
        .DO   (dout),
        .DSO  (dso),
        .BUSY (busy),
        .ERR  (err)
    );

    typedef struct {
        int t;
        int med;
        int id;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    exp_t mon_e;
    int   cyc_num  = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   batch_id = 0;
    int   busy_lo  = 0;
    int   busy_hi  = 0;
    bit   watch_busy = 1'b0;

    always @(posedge clk) cyc_num <= cyc_num + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc_num);
        end
    endtask

    // Reference: sort the burst and take the middle element.
    function automatic int ref_median(input int v[P]);
        int q[$];
        foreach (v[k]) q.push_back(v[k]);
        q.sort();
        return q[P / 2];
    endfunction

    // Monitor: pops the scoreboard on every DSO/ERR and flags anything missing or extra.
    always @(negedge clk) begin
        if (dso) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_dso: got DSO with DO=%0d, required no DSO (cycle %0d)", dout, cyc_num);
            end else begin
                mon_e = exp_q.pop_front();
                check("dso_cycle", cyc_num, mon_e.t);
                check("median", int'(dout), mon_e.med);
                $display("batch %0d: DSO at cycle %0d DO=%0d (model %0d)", mon_e.id, cyc_num, dout, mon_e.med);
            end
        end else if (exp_q.size() > 0 && exp_q[0].t < cyc_num) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_dso: batch %0d got no DSO, required at cycle %0d", mon_e.id, mon_e.t);
        end
        if (err) begin
            if (err_q.size() > 0 && err_q[0] == cyc_num) begin
                void'(err_q.pop_front());
                n_cmp++;
                $display("abort: ERR at cycle %0d", cyc_num);
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_err: got ERR=1, required 0 (cycle %0d)", cyc_num);
            end
        end else if (err_q.size() > 0 && err_q[0] < cyc_num) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_err: got ERR=0, required 1 at cycle %0d", err_q.pop_front());
        end
        if (watch_busy && busy_hi > 0 && cyc_num >= busy_lo && cyc_num <= busy_hi + 1) begin
            check("busy_window", int'(busy), (cyc_num <= busy_hi) ? 1 : 0);
        end
    end

    // Drives one full burst, then the sort window (optional DSI noise or a reset).
    // b2b leaves the next call's first sample landing in this batch's DONE cycle.
    task automatic send_batch(input int v[P], input bit b2b, input bit glitch, input int rst_at);
        int t0;
        exp_t e;
        t0 = 0;
        for (int k = 0; k < P; k++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            di  = W'(v[k]);
            dsi = 1'b1;
            if (k == 0) begin
                t0 = cyc_num;
                if (watch_busy) begin
                    busy_lo = t0;
                    busy_hi = t0 + LAT;
                end
            end
        end
        batch_id++;
        if (rst_at < 0) begin
            e.t   = t0 + LAT;
            e.med = ref_median(v);
            e.id  = batch_id;
            exp_q.push_back(e);
        end
        while (1) begin
            @(posedge clk);
            #1;
            rst = (rst_at >= 0) && (cyc_num == t0 + rst_at);
            dsi = 1'b0;
            if (glitch && rst_at < 0 && cyc_num <= t0 + LAT - 1 && $urandom_range(0, 1) == 1)
                dsi = 1'b1;
            di = W'($urandom);
            if (rst_at >= 0 && cyc_num == t0 + rst_at + 1) begin
                @(negedge clk);
                check("busy_after_rst", int'(busy), 0);
            end
            if (b2b && cyc_num >= t0 + LAT - 1) break;
            if (!b2b && cyc_num >= t0 + LAT + 3) break;
        end
    endtask

    task automatic send_abort(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            di  = W'($urandom);
            dsi = 1'b1;
        end
        @(posedge clk);
        #1;
        dsi = 1'b0;
        err_q.push_back(cyc_num);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: got no finish, required end within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v[P];
        bit b2b;
        rst = 1'b1;
        dsi = 1'b0;
        di  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dso", int'(dso), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_dso", int'(dso), 0);

        watch_busy = 1'b1;
        v = '{7, 3, 9, 1, 5, 8, 2, 6, 4};
        send_batch(v, 1'b0, 1'b0, -1);
        watch_busy = 1'b0;

        v = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        send_batch(v, 1'b0, 1'b0, -1);
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        send_batch(v, 1'b0, 1'b0, -1);

        v = '{255, 0, 255, 0, 255, 0, 255, 0, 0};
        send_batch(v, 1'b0, 1'b0, -1);
        v = '{128, 128, 128, 128, 128, 128, 128, 128, 128};
        send_batch(v, 1'b0, 1'b0, -1);

        send_abort(5);
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        send_batch(v, 1'b0, 1'b0, -1);

        v = '{50, 60, 70, 80, 90, 100, 110, 120, 130};
        send_batch(v, 1'b0, 1'b0, 20);
        v = '{2, 2, 2, 9, 9, 9, 1, 1, 1};
        send_batch(v, 1'b0, 1'b0, -1);

        v = '{10, 200, 30, 40, 250, 60, 70, 80, 90};
        send_batch(v, 1'b1, 1'b0, -1);
        v = '{5, 4, 3, 2, 1, 9, 8, 7, 6};
        send_batch(v, 1'b0, 1'b1, -1);

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < P; k++) begin
                v[k] = (i % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            end
            b2b = (i < 15) && ($urandom_range(0, 1) == 1);
            send_batch(v, b2b, ($urandom_range(0, 2) == 0), -1);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pending_medians", exp_q.size(), 0);
        check("pending_errs", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
